seqdiv_nr: RTL and testbench
============================

// Module: seqdiv_nr
// PURPOSE
//  Parametrised multi-cycle non-restoring divider computing (dividend << FRAC_W) / divisor.
//  Successor to the fixed 19-bit sample divider.
//  Adds configurable widths, a busy/done handshake, divide-by-zero and saturation flags,
//  abort-on-restart, and an optional remainder output.
//  Sits between the oscillator counters and the waveshaper; one instance per voice.
// PARAMETERS
//  CNT_W   19  width of dividend (oscillator count) and divisor (frequency table entry)
//  FRAC_W   8  left shift applied to dividend (x2^FRAC_W scaling)
//  Q_W      9  width of quotient output; larger results saturate
// PORTS
//  clk        in   1      system clock, all state on posedge
//  RST        in   1      asynchronous active-low reset
//  start      in   1      1-cycle request pulse; latches operands
//  dividend   in   CNT_W  numerator before scaling
//  divisor    in   CNT_W  denominator
//  busy       out  1      high while an operation is in flight (CALC/FIX)
//  done       out  1      high from result-ready until next start or reset
//  quotient   out  Q_W    result, valid while done=1, held otherwise
//  dbz        out  1      divisor was zero for the current result
//  sat        out  1      true quotient exceeded 2^Q_W-1
//  remainder  out  CNT_W  only with SEQDIV_REM_EN (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (RST=0, async): state=IDLE; busy, done, dbz, sat=0; quotient=0; internal regs=0.
//  - Internal width N=CNT_W+FRAC_W. Q reg N bits = {dividend,FRAC_W'0}. M reg = divisor zero-ext to N+1.
//    A reg N+1 bits, sign = MSB.
//  - FSM IDLE -> CALC -> FIX -> DONE. start in ANY state wins.
//    * start: latch operands, clear done/dbz/sat, C=0, go CALC; divisor==0 goes to FIX directly.
//  - CALC, one iteration per cycle:
//    * {A,Q} <<= 1; A = A[N] ? A+M : A-M; Q[0] = ~A_new[N]; C++.
//    * After N iterations go to FIX.
//  - FIX (1 cycle):
//    * if A negative then A += M (remainder restore).
//    * If divisor==0: quotient = all ones, dbz=1.
//    * Else if Q >= 2^Q_W: quotient = all ones, sat=1.
//    * Else quotient = Q[Q_W-1:0].
//    * Then done=1 and go to DONE.
//  - Latency: start sampled at edge E0 -> done high after edge E(N+1).
//    N+2 cycles total, i.e. 29 at defaults. Divide-by-zero: done after E1.
//  - DONE: outputs held; done stays 1 until next start. Start in DONE drops done next cycle.
//  - Restart mid-CALC/FIX: current op silently aborted, no done pulse for it.
//    New op full latency from its own start.
//  - Mid-operation reset: immediate return to reset values; no spurious done after release.
//  - busy=1 exactly in CALC and FIX; busy and done never both 1.
//  - Operands unsigned; dividend >= divisor is legal (saturation covers overflow).
// CONFIGURATION
//  SEQDIV_REM_EN defined:
//    * remainder port present; = restored A[CNT_W-1:0] registered in FIX.
//    * 0 on dbz/reset; held like quotient.
//  SEQDIV_REM_EN undefined:
//    * port absent.
//    * FIX skips the restore add; A correction logic not synthesised.
// STRUCTURE
//  - seqdiv_pkg:
//    * typedef enum logic [1:0] {IDLE,CALC,FIX,DONE} seqdiv_state_t.
//    * Default width localparams (CNT_W_DEF=19, FRAC_W_DEF=8, Q_W_DEF=9).
//  - Sub-module seqdiv_step (combinational, parametrised by N):
//    * one shift/add-sub iteration: in {A,Q,M}, out {A',Q'}.
//  - Top holds FSM, iteration counter $clog2(N+1) bits, operand/result registers.
// TESTING
//  1 dividend=1000, divisor=4000 -> quotient=64, dbz=0, sat=0; done after 29 cycles; busy 28 cycles.
//  2 divisor=0, dividend=77 -> done after 2 cycles, quotient=511, dbz=1, sat=0.
//  3 dividend=5000, divisor=2000 (true 640) -> quotient=511, sat=1.
//  4 start 100/200, restart at cycle 10 with 300/600 -> single done, 29 cycles after 2nd start, quotient=128.
//  5 start 1000/4000, RST low at cycle 15 -> busy=done=quotient=0; after release 1000/3000 -> 85.
//  6 SEQDIV_REM_EN, 1000/3000 -> quotient=85, remainder=1000; repeat without macro: quotient=85, builds.

Source files
------------

// File: rtl/seqdiv_nr_pkg.sv
// Shared state encoding and default widths for the seqdiv_nr non-restoring divider.
package seqdiv_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} seqdiv_state_t;

  localparam int CNT_W_DEF  = 19;
  localparam int FRAC_W_DEF = 8;
  localparam int Q_W_DEF    = 9;

endpackage

// File: rtl/seqdiv_nr_if.sv
// Request/result bundle for seqdiv_nr; remainder exists only when SEQDIV_REM_EN is defined.
interface seqdiv_nr_if
  import seqdiv_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int Q_W   = Q_W_DEF
);

  logic             start;
  logic [CNT_W-1:0] dividend;
  logic [CNT_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [Q_W-1:0]   quotient;
  logic             dbz;
  logic             sat;
`ifdef SEQDIV_REM_EN
  logic [CNT_W-1:0] remainder;
`endif

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, dbz, sat
`ifdef SEQDIV_REM_EN
    , remainder
`endif
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, dbz, sat
`ifdef SEQDIV_REM_EN
    , remainder
`endif
  );

endinterface

// File: rtl/seqdiv_nr_step.sv
// One combinational non-restoring iteration: shift {A,Q} left, add or subtract M, set quotient bit.
module seqdiv_step #(
  parameter int N = 27
) (
  input  logic [N:0]   a,
  input  logic [N-1:0] q,
  input  logic [N:0]   m,
  output logic [N:0]   a_next,
  output logic [N-1:0] q_next
);

  logic [N:0] a_sh;

  // The partial remainder never exceeds |M| < 2^(N-1), so the sign survives the shift.
  assign a_sh   = {a[N-1:0], q[N-1]};
  assign a_next = a[N] ? (a_sh + m) : (a_sh - m);
  assign q_next = {q[N-2:0], ~a_next[N]};

endmodule

// File: rtl/seqdiv_nr.sv
// Multi-cycle (dividend << FRAC_W) / divisor with busy/done handshake, dbz and saturation flags.
// Define SEQDIV_REM_EN to add the restored remainder output.
module seqdiv_nr
  import seqdiv_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int Q_W    = Q_W_DEF
) (
  input  logic      clk,
  input  logic      RST,
  seqdiv_nr_if.slave bus
);

  localparam int N  = CNT_W + FRAC_W;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST  = CW'(N - 1);
  localparam logic [N-1:0]  Q_MAX = N'((1 << Q_W) - 1);

  seqdiv_state_t  state;
  logic [N:0]     a;
  logic [N-1:0]   q;
  logic [N:0]     m;
  logic [CW-1:0]  cnt;
  logic           busy_r;
  logic           done_r;
  logic [Q_W-1:0] quo_r;
  logic           dbz_r;
  logic           sat_r;
  logic [N:0]     a_next;
  logic [N-1:0]   q_next;

  seqdiv_step #(.N(N)) u_step (
    .a      (a),
    .q      (q),
    .m      (m),
    .a_next (a_next),
    .q_next (q_next)
  );

`ifdef SEQDIV_REM_EN
  logic [CNT_W-1:0] rem_r;
  logic [N:0]       a_fix;

  assign a_fix = a[N] ? (a + m) : a;
`endif

  // A new start preempts whatever is in flight, so it is checked ahead of the state decode.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state  <= IDLE;
      a      <= '0;
      q      <= '0;
      m      <= '0;
      cnt    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quo_r  <= '0;
      dbz_r  <= 1'b0;
      sat_r  <= 1'b0;
`ifdef SEQDIV_REM_EN
      rem_r  <= '0;
`endif
    end else if (bus.start) begin
      a      <= '0;
      q      <= {bus.dividend, {FRAC_W{1'b0}}};
      m      <= (N + 1)'(bus.divisor);
      cnt    <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      sat_r  <= 1'b0;
      state  <= (bus.divisor == '0) ? FIX : CALC;
    end else begin
      case (state)
        CALC: begin
          a   <= a_next;
          q   <= q_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= DONE;
`ifdef SEQDIV_REM_EN
          a      <= a_fix;
          rem_r  <= (m == '0) ? '0 : a_fix[CNT_W-1:0];
`endif
          if (m == '0) begin
            quo_r <= '1;
            dbz_r <= 1'b1;
          end else if (q > Q_MAX) begin
            quo_r <= '1;
            sat_r <= 1'b1;
          end else begin
            quo_r <= q[Q_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.quotient = quo_r;
  assign bus.dbz      = dbz_r;
  assign bus.sat      = sat_r;
`ifdef SEQDIV_REM_EN
  assign bus.remainder = rem_r;
`endif

endmodule

// File: tb/tb_seqdiv_nr.sv
// Self-checking bench for seqdiv_nr; reference results come from plain integer division.
// Remainder checks are compiled in when SEQDIV_REM_EN is defined.
module tb_seqdiv_nr;
  import seqdiv_pkg::*;

  localparam int CNT_W  = 19;
  localparam int FRAC_W = 8;
  localparam int Q_W    = 9;
  localparam int N      = CNT_W + FRAC_W;
  localparam int Q_ALL  = (1 << Q_W) - 1;
  localparam int BOUND  = 200;

  logic clk = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;

  seqdiv_nr_if #(.CNT_W(CNT_W), .Q_W(Q_W)) bus ();

  seqdiv_nr #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .Q_W(Q_W)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: exact scaled division, clipped to the quotient range.
  function automatic void model(input longint dvd, input longint dvs, output longint q,
                                output bit dbz, output bit sat, output longint rem);
    longint num;
    num = dvd << FRAC_W;
    dbz = (dvs == 0);
    sat = 1'b0;
    rem = 0;
    q   = Q_ALL;
    if (!dbz) begin
      q   = num / dvs;
      rem = num % dvs;
      if (q > Q_ALL) begin
        sat = 1'b1;
        q   = Q_ALL;
      end
    end
  endfunction

  task automatic do_start(input longint dvd, input longint dvs);
    @(negedge clk);
    bus.dividend = CNT_W'(dvd);
    bus.divisor  = CNT_W'(dvs);
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // lat counts clock edges after the start edge until done is seen.
  task automatic wait_done(output int lat, output int busy_n, output bit overlap);
    lat = 0;
    busy_n = 0;
    overlap = 1'b0;
    while (bus.done !== 1'b1 && lat < BOUND) begin
      if (bus.busy === 1'b1) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
    if (bus.busy === 1'b1 && bus.done === 1'b1) overlap = 1'b1;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    RST = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %0b want 0", bus.done); end
    checks++;
    if (bus.quotient !== '0) begin errors++; $display("[TB] FAIL reset_quotient got %0d want 0", bus.quotient); end
    checks++;
    if ({bus.dbz, bus.sat} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags got %b want 00", {bus.dbz, bus.sat}); end
    @(negedge clk);
    RST = 1'b1;
  endtask

  task automatic test_basic();
    int lat, bn;
    bit ov;
    do_start(1000, 4000);
    wait_done(lat, bn, ov);
    checks++;
    if (lat !== N + 1) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", lat, N + 1); end
    checks++;
    if (bn !== N + 1) begin errors++; $display("[TB] FAIL basic_busy_cycles got %0d want %0d", bn, N + 1); end
    checks++;
    if (ov !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_done_overlap got 1 want 0"); end
    checks++;
    if (bus.quotient !== Q_W'(64)) begin errors++; $display("[TB] FAIL basic_quotient got %0d want 64", bus.quotient); end
    checks++;
    if ({bus.dbz, bus.sat} !== 2'b00) begin errors++; $display("[TB] FAIL basic_flags got %b want 00", {bus.dbz, bus.sat}); end
  endtask

  task automatic test_done_hold();
    int lat, bn;
    bit ov;
    repeat (5) begin @(posedge clk); #1; end
    checks++;
    if (bus.done !== 1'b1 || bus.quotient !== Q_W'(64)) begin
      errors++; $display("[TB] FAIL hold got done=%0b q=%0d want done=1 q=64", bus.done, bus.quotient);
    end
    do_start(1000, 3000);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL restart_from_done got done=%0b busy=%0b want 0/1", bus.done, bus.busy);
    end
    wait_done(lat, bn, ov);
    checks++;
    if (bus.quotient !== Q_W'(85)) begin errors++; $display("[TB] FAIL q85 got %0d want 85", bus.quotient); end
`ifdef SEQDIV_REM_EN
    checks++;
    if (bus.remainder !== CNT_W'(1000)) begin errors++; $display("[TB] FAIL rem1000 got %0d want 1000", bus.remainder); end
`endif
  endtask

  task automatic test_dbz();
    int lat, bn;
    bit ov;
    do_start(77, 0);
    wait_done(lat, bn, ov);
    checks++;
    if (lat !== 1) begin errors++; $display("[TB] FAIL dbz_latency got %0d want 1", lat); end
    checks++;
    if (bus.quotient !== Q_W'(Q_ALL)) begin errors++; $display("[TB] FAIL dbz_quotient got %0d want %0d", bus.quotient, Q_ALL); end
    checks++;
    if ({bus.dbz, bus.sat} !== 2'b10) begin errors++; $display("[TB] FAIL dbz_flags got %b want 10", {bus.dbz, bus.sat}); end
`ifdef SEQDIV_REM_EN
    checks++;
    if (bus.remainder !== '0) begin errors++; $display("[TB] FAIL dbz_rem got %0d want 0", bus.remainder); end
`endif
  endtask

  task automatic test_sat();
    int lat, bn;
    bit ov;
    do_start(5000, 2000);
    wait_done(lat, bn, ov);
    checks++;
    if (lat !== N + 1) begin errors++; $display("[TB] FAIL sat_latency got %0d want %0d", lat, N + 1); end
    checks++;
    if (bus.quotient !== Q_W'(Q_ALL)) begin errors++; $display("[TB] FAIL sat_quotient got %0d want %0d", bus.quotient, Q_ALL); end
    checks++;
    if ({bus.dbz, bus.sat} !== 2'b01) begin errors++; $display("[TB] FAIL sat_flags got %b want 01", {bus.dbz, bus.sat}); end
  endtask

  task automatic test_restart();
    int lat, bn;
    bit ov, seen;
    seen = 1'b0;
    do_start(100, 200);
    repeat (9) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    do_start(300, 600);
    wait_done(lat, bn, ov);
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL restart_early_done got 1 want 0"); end
    checks++;
    if (lat !== N + 1) begin errors++; $display("[TB] FAIL restart_latency got %0d want %0d", lat, N + 1); end
    checks++;
    if (bus.quotient !== Q_W'(128)) begin errors++; $display("[TB] FAIL restart_quotient got %0d want 128", bus.quotient); end
  endtask

  task automatic test_mid_reset();
    int lat, bn;
    bit ov, seen;
    seen = 1'b0;
    do_start(1000, 4000);
    repeat (14) begin @(posedge clk); #1; end
    #2 RST = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.quotient !== '0) begin
      errors++; $display("[TB] FAIL midreset got busy=%0b done=%0b q=%0d want 0/0/0", bus.busy, bus.done, bus.quotient);
    end
    @(negedge clk);
    RST = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("[TB] FAIL midreset_spurious_done got 1 want 0"); end
    do_start(1000, 3000);
    wait_done(lat, bn, ov);
    checks++;
    if (bus.quotient !== Q_W'(85) || lat !== N + 1) begin
      errors++; $display("[TB] FAIL post_reset got q=%0d lat=%0d want 85/%0d", bus.quotient, lat, N + 1);
    end
  endtask

  task automatic test_random();
    int lat, bn;
    bit ov, e_dbz, e_sat;
    longint dvd, dvs, e_q, e_rem;
    for (int i = 0; i < 24; i++) begin
      dvd = $urandom_range(0, (1 << CNT_W) - 1);
      case ($urandom_range(0, 3))
        0:       dvs = 0;
        1:       dvs = $urandom_range(1, 255);
        default: dvs = $urandom_range(1, (1 << CNT_W) - 1);
      endcase
      model(dvd, dvs, e_q, e_dbz, e_sat, e_rem);
      do_start(dvd, dvs);
      wait_done(lat, bn, ov);
      checks++;
      if (bus.quotient !== Q_W'(e_q) || {bus.dbz, bus.sat} !== {e_dbz, e_sat}) begin
        errors++;
        $display("[TB] FAIL rand_result %0d/%0d got q=%0d f=%b want q=%0d f=%b",
                 dvd, dvs, bus.quotient, {bus.dbz, bus.sat}, e_q, {e_dbz, e_sat});
      end
      checks++;
      if (lat !== (e_dbz ? 1 : N + 1) || ov !== 1'b0) begin
        errors++; $display("[TB] FAIL rand_timing %0d/%0d got lat=%0d ov=%0b", dvd, dvs, lat, ov);
      end
`ifdef SEQDIV_REM_EN
      checks++;
      if (bus.remainder !== CNT_W'(e_rem)) begin
        errors++; $display("[TB] FAIL rand_rem %0d/%0d got %0d want %0d", dvd, dvs, bus.remainder, e_rem);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_done_hold();
    test_dbz();
    test_sat();
    test_restart();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
